collision_ctrl: RTL and testbench



---
 rtl/collision_ctrl.sv | 176 +++++++++++++++++
 tb/tb_collision_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_ctrl.sv
// Game-state controller for the flappy-bird datapath: two-stage collision/pass
// detection against two pipes and the floor, IDLE/RUN/DEAD FSM, saturating BCD score.
module collision_ctrl #(
  parameter int BIRD_X      = 100,
  parameter int BIRD_WIDTH  = 16,
  parameter int BIRD_HEIGHT = 16,
  parameter int PIPE_WIDTH  = 40,
  parameter int GAP_HEIGHT  = 120,
  parameter int DEAD_HOLD   = 30
) (
  input  logic               gameClk,
  input  logic               reset_n,
  input  logic               button,
  input  logic signed [10:0] y_in,
  input  logic signed [10:0] pipe0_x,
  input  logic signed [10:0] pipe1_x,
  input  logic signed [10:0] pipe0_gap,
  input  logic signed [10:0] pipe1_gap,
  output logic               finished,
  output logic               restart,
  output logic [7:0]         score,
  output logic [1:0]         state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam int HOLD_W = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;

  // 12-bit signed so that coordinate + extent can never wrap
  localparam logic signed [11:0] BX = 12'(BIRD_X);
  localparam logic signed [11:0] BW = 12'(BIRD_WIDTH);
  localparam logic signed [11:0] BH = 12'(BIRD_HEIGHT);
  localparam logic signed [11:0] PW = 12'(PIPE_WIDTH);
  localparam logic signed [11:0] GH = 12'(GAP_HEIGHT);

  typedef struct packed {
    logic h;
    logic safe;
    logic behind;
    logic ahead;
  } pflags_t;

  function automatic pflags_t pipe_flags(input logic signed [11:0] px,
                                         input logic signed [11:0] gap,
                                         input logic signed [11:0] y);
    pflags_t f;
    f.h      = (px < BX + BW) && (px + PW > BX);
    f.safe   = (y - BH > gap) && (y < gap + GH);
    f.behind = (px + PW < BX);
    f.ahead  = (px >= BX);
    return f;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99) return s;
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  logic signed [11:0] y_s, p0x_s, p1x_s, p0g_s, p1g_s;
  assign y_s   = {y_in[10], y_in};
  assign p0x_s = {pipe0_x[10], pipe0_x};
  assign p1x_s = {pipe1_x[10], pipe1_x};
  assign p0g_s = {pipe0_gap[10], pipe0_gap};
  assign p1g_s = {pipe1_gap[10], pipe1_gap};

  logic              btn_q;
  pflags_t           f0_q, f1_q;
  logic              floor_q;
  logic              hit_q;
  logic [1:0]        pass_q, pass_d;
  logic [1:0]        passed_q, passed_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        guard_q, guard_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        score_q, score_d;
  logic              restart_q, restart_d;
  logic              press, start;

  assign press = button & ~btn_q;

  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    hold_d    = hold_q;
    score_d   = score_q;
    restart_d = 1'b0;
    start     = 1'b0;
    case (state_q)
      S_IDLE: if (press) start = 1'b1;
      S_RUN: begin
        // a pass on the same tick as a hit still counts
        case (pass_q)
          2'b11:        score_d = bcd_inc(bcd_inc(score_q));
          2'b01, 2'b10: score_d = bcd_inc(score_q);
          default:      score_d = score_q;
        endcase
        if (guard_q != 2'd0) begin
          guard_d = guard_q - 2'd1;
        end else if (hit_q) begin
          state_d = S_DEAD;
          hold_d  = HOLD_W'(DEAD_HOLD);
        end
      end
      S_DEAD: begin
        if (hold_q != '0) hold_d = hold_q - 1'b1;
        else if (press)   start  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) begin
      state_d   = S_RUN;
      restart_d = 1'b1;
      score_d   = 8'h00;
      guard_d   = 2'd2;
    end
  end

  // Pass latch re-arms when the pipe reappears ahead of the bird
  always_comb begin
    passed_d = passed_q;
    pass_d   = 2'b00;
    if (start) begin
      passed_d = 2'b00;
    end else begin
      if (f0_q.ahead) passed_d[0] = 1'b0;
      else if (f0_q.behind && !passed_q[0]) begin
        passed_d[0] = 1'b1;
        pass_d[0]   = 1'b1;
      end
      if (f1_q.ahead) passed_d[1] = 1'b0;
      else if (f1_q.behind && !passed_q[1]) begin
        passed_d[1] = 1'b1;
        pass_d[1]   = 1'b1;
      end
    end
  end

  always_ff @(posedge gameClk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q     <= 1'b0;
      f0_q      <= '0;
      f1_q      <= '0;
      floor_q   <= 1'b0;
      hit_q     <= 1'b0;
      pass_q    <= 2'b00;
      passed_q  <= 2'b00;
      state_q   <= S_IDLE;
      guard_q   <= 2'd0;
      hold_q    <= '0;
      score_q   <= 8'h00;
      restart_q <= 1'b0;
    end else begin
      btn_q     <= button;
      f0_q      <= pipe_flags(p0x_s, p0g_s, y_s);
      f1_q      <= pipe_flags(p1x_s, p1g_s, y_s);
      floor_q   <= (y_s <= BH);
      hit_q     <= floor_q | (f0_q.h & ~f0_q.safe) | (f1_q.h & ~f1_q.safe);
      pass_q    <= pass_d;
      passed_q  <= passed_d;
      state_q   <= state_d;
      guard_q   <= guard_d;
      hold_q    <= hold_d;
      score_q   <= score_d;
      restart_q <= restart_d;
    end
  end

  assign finished = (state_q != S_RUN);
  assign restart  = restart_q;
  assign score    = score_q;
  assign state    = state_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: start, flight, collisions, scoring, death hold, guard, reset.
module tb_collision_ctrl;
  logic               gameClk = 1'b0;
  logic               reset_n;
  logic               button;
  logic signed [10:0] y_in, pipe0_x, pipe1_x, pipe0_gap, pipe1_gap;
  logic               finished, restart;
  logic [7:0]         score;
  logic [1:0]         state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 gameClk = ~gameClk;

  collision_ctrl dut (
    .gameClk   (gameClk),
    .reset_n   (reset_n),
    .button    (button),
    .y_in      (y_in),
    .pipe0_x   (pipe0_x),
    .pipe1_x   (pipe1_x),
    .pipe0_gap (pipe0_gap),
    .pipe1_gap (pipe1_gap),
    .finished  (finished),
    .restart   (restart),
    .score     (score),
    .state     (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gameClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One pipe goes ahead (re-arm) then behind the bird
  task automatic pass_one();
    pipe0_x = 11'sd100; tick();
    pipe0_x = 11'sd59;  tick();
  endtask

  task automatic pass_both();
    pipe0_x = 11'sd100; pipe1_x = 11'sd100; tick();
    pipe0_x = 11'sd59;  pipe1_x = 11'sd59;  tick();
  endtask

  task automatic park_and_settle();
    pipe0_x = 11'sd400; pipe1_x = 11'sd400; ticks(3);
  endtask

  initial begin
    int bad;
    int incs;
    int at_x;
    logic [7:0] prev;

    reset_n = 1'b0; button = 1'b0; y_in = 11'sd200;
    pipe0_x = 11'sd400; pipe0_gap = 11'sd150;
    pipe1_x = 11'sd400; pipe1_gap = 11'sd150;
    ticks(2);
    check("rst_state", 32'(state), 0);
    check("rst_finished", 32'(finished), 1);
    check("rst_score", 32'(score), 32'h00);
    check("rst_restart", 32'(restart), 0);

    reset_n = 1'b1; tick();
    check("idle_wait", 32'(state), 0);
    button = 1'b1; tick();
    check("start_state", 32'(state), 1);
    check("start_restart", 32'(restart), 1);
    check("start_finished", 32'(finished), 0);
    tick();
    check("restart_pulse_end", 32'(restart), 0);
    button = 1'b0;

    // Bird 184..200 inside gap 150..270 while overlapping pipe0
    pipe0_x = 11'sd90;
    bad = 0;
    repeat (20) begin
      tick();
      if (state !== 2'd1) bad++;
    end
    check("clear_flight", 32'(bad), 0);

    // Score moves three edges after the first behind sample (x=59)
    incs = 0; at_x = -1; prev = score;
    for (int x = 120; x >= 50; x--) begin
      pipe0_x = 11'(x);
      tick();
      if (score !== prev) begin
        incs++;
        if (at_x < 0) at_x = x + 2;
        prev = score;
      end
    end
    ticks(3);
    check("sweep1_score", 32'(score), 32'h01);
    check("sweep1_incs", 32'(incs), 1);
    check("sweep1_at_x", 32'(at_x), 59);

    pipe0_x = 11'sd400; ticks(3);
    for (int x = 120; x >= 50; x--) begin
      pipe0_x = 11'(x);
      tick();
    end
    ticks(3);
    check("sweep2_score", 32'(score), 32'h02);

    pipe0_x = 11'sd90; ticks(3);
    check("pre_collide", 32'(state), 1);
    y_in = 11'sd160; ticks(2);
    check("collide_lat2", 32'(state), 1);
    tick();
    check("collide_dead", 32'(state), 2);
    check("dead_finished", 32'(finished), 1);
    check("dead_keeps_score", 32'(score), 32'h02);

    y_in = 11'sd200; ticks(9);
    button = 1'b1; tick();
    check("press_in_hold", 32'(state), 2);
    button = 1'b0; ticks(20);
    check("hold_end", 32'(state), 2);
    button = 1'b1; tick();
    check("rerun_state", 32'(state), 1);
    check("rerun_restart", 32'(restart), 1);
    check("rerun_score", 32'(score), 32'h00);
    button = 1'b0; tick();
    check("rerun_restart_end", 32'(restart), 0);

    pipe0_x = 11'sd400; y_in = 11'sd17; ticks(5);
    check("y17_no_hit", 32'(state), 1);
    y_in = 11'sd16; ticks(2);
    check("floor_lat2", 32'(state), 1);
    tick();
    check("floor_dead", 32'(state), 2);

    y_in = 11'sd200; ticks(5);
    button = 1'b1; ticks(35);
    check("held_button_no_press", 32'(state), 2);
    button = 1'b0; tick();
    button = 1'b1; tick();
    check("press_after_release", 32'(state), 1);
    button = 1'b0;

    repeat (9) pass_one();
    park_and_settle();
    check("score_09", 32'(score), 32'h09);
    pass_one();
    park_and_settle();
    check("bcd_carry_10", 32'(score), 32'h10);
    repeat (44) pass_both();
    park_and_settle();
    check("score_98", 32'(score), 32'h98);
    pass_both();
    park_and_settle();
    check("sat_99", 32'(score), 32'h99);
    pass_both();
    park_and_settle();
    check("sat_hold", 32'(score), 32'h99);

    y_in = 11'sd16; ticks(3);
    check("pre_guard_dead", 32'(state), 2);
    ticks(30);
    pipe0_x = 11'sd90; y_in = 11'sd160;
    button = 1'b1; tick();
    check("guard_start", 32'(state), 1);
    button = 1'b0; tick();
    check("guard_t1", 32'(state), 1);
    tick();
    check("guard_t2", 32'(state), 1);
    tick();
    check("guard_expire", 32'(state), 2);

    y_in = 11'sd200; pipe0_x = 11'sd400; ticks(30);
    button = 1'b1; tick();
    button = 1'b0;
    check("run_before_reset", 32'(state), 1);
    pass_one();
    park_and_settle();
    check("pre_reset_score", 32'(score), 32'h01);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 0);
    check("async_rst_score", 32'(score), 32'h00);
    check("async_rst_finished", 32'(finished), 1);
    check("async_rst_restart", 32'(restart), 0);
    tick();
    reset_n = 1'b1; tick();
    check("post_reset_idle", 32'(state), 0);
    check("post_reset_restart", 32'(restart), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
